// File: rtl/pipeline_hazard_controller_pkg.sv
// rtl/pipeline_hazard_controller_pkg.sv - shared widths and FSM state type for the hazard controller
package pipeline_hazard_controller_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;

    typedef enum logic {
        HZ_RUN,
        HZ_FLUSH
    } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_reg_scoreboard.sv
// rtl/pipeline_hazard_controller_reg_scoreboard.sv - per-register in-flight write counters with sticky underflow
module pipeline_hazard_controller_reg_scoreboard
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inc_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] inc_rd_i,
    input  logic                      dec_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] dec_rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    output logic [CNT_WIDTH-1:0]      rs1_cnt_o,
    output logic [CNT_WIDTH-1:0]      rs2_cnt_o,
    output logic [CNT_WIDTH-1:0]      rd_cnt_o,
    output logic                      underflow_o
);

    logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
    logic                 underflow_q;
    logic                 underflow_d;
    logic                 inc;
    logic                 dec;

    assign inc = inc_en_i & (inc_rd_i != '0);
    assign dec = dec_en_i & (dec_rd_i != '0);

    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (dec && cnt_q[dec_rd_i] == '0) begin
            underflow_d = 1'b1;
        end
        // An issue and a retire on the same register cancel out.
        if (!(inc && dec && inc_rd_i == dec_rd_i)) begin
            if (inc) begin
                cnt_d[inc_rd_i] = cnt_q[inc_rd_i] + CNT_WIDTH'(1);
            end
            if (dec && cnt_q[dec_rd_i] != '0) begin
                cnt_d[dec_rd_i] = cnt_q[dec_rd_i] - CNT_WIDTH'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign rs1_cnt_o   = cnt_q[rs1_i];
    assign rs2_cnt_o   = cnt_q[rs2_i];
    assign rd_cnt_o    = cnt_q[rd_i];
    assign underflow_o = underflow_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - issue gating, branch redirect and flush sequencing (optional PIPELINE_HAZARD_PERF_EN counters)
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int CNT_WIDTH    = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1_i,
    input  logic                      issue_rs1_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2_i,
    input  logic                      issue_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
    input  logic                      issue_rd_we_i,
    input  logic                      downstream_ready_i,
    output logic                      issue_ready_o,
    input  logic                      ex_valid_i,
    input  logic                      branch_taken_i,
    input  logic [REGISTER_WIDTH-1:0] branch_target_i,
    input  logic                      wb_valid_i,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    output logic                      redirect_valid_o,
    output logic [REGISTER_WIDTH-1:0] redirect_target_o,
    output logic                      flush_o,
    output logic                      sb_underflow_o
`ifdef PIPELINE_HAZARD_PERF_EN
    ,
    output logic [31:0]               stall_count_o,
    output logic [31:0]               flush_count_o
`endif
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    hazard_state_t             state_q, state_d;
    logic [FCW-1:0]            fcnt_q, fcnt_d;
    logic                      redirect_q, redirect_d;
    logic [REGISTER_WIDTH-1:0] target_q, target_d;

    logic [CNT_WIDTH-1:0] rs1_cnt, rs2_cnt, rd_cnt;
    logic                 hazard;
    logic                 branch;
    logic                 fire;

    assign branch = ex_valid_i & branch_taken_i;
    assign hazard = (issue_rs1_used_i & (issue_rs1_i != '0) & (rs1_cnt != '0))
                  | (issue_rs2_used_i & (issue_rs2_i != '0) & (rs2_cnt != '0))
                  | (issue_rd_we_i    & (issue_rd_i  != '0) & (rd_cnt == CNT_MAX));

    assign issue_ready_o = rst_n & (state_q == HZ_RUN) & downstream_ready_i & ~hazard & ~branch;
    assign fire          = issue_valid_i & issue_ready_o;

    pipeline_hazard_controller_reg_scoreboard #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_en_i   (fire & issue_rd_we_i),
        .inc_rd_i   (issue_rd_i),
        .dec_en_i   (wb_valid_i & wb_we_i),
        .dec_rd_i   (wb_rd_i),
        .rs1_i      (issue_rs1_i),
        .rs2_i      (issue_rs2_i),
        .rd_i       (issue_rd_i),
        .rs1_cnt_o  (rs1_cnt),
        .rs2_cnt_o  (rs2_cnt),
        .rd_cnt_o   (rd_cnt),
        .underflow_o(sb_underflow_o)
    );

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        case (state_q)
            HZ_RUN: begin
                if (branch) begin
                    state_d    = HZ_FLUSH;
                    fcnt_d     = FCW'(FLUSH_CYCLES - 1);
                    redirect_d = 1'b1;
                    target_d   = branch_target_i;
                end
            end
            HZ_FLUSH: begin
                // Branches seen here belong to squashed instructions.
                if (fcnt_q == '0) begin
                    state_d = HZ_RUN;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HZ_RUN;
            fcnt_q     <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
        end
    end

    assign redirect_valid_o  = redirect_q;
    assign redirect_target_o = target_q;
    assign flush_o           = (state_q == HZ_FLUSH);

`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (issue_valid_i && hazard) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_d) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - randomized scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    localparam int CNT_MAX = 3;
    localparam int FC      = 2;
    localparam int NCYC    = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_rs1_i = '0;
    logic        issue_rs1_used_i = 1'b0;
    logic [4:0]  issue_rs2_i = '0;
    logic        issue_rs2_used_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_rd_we_i = 1'b0;
    logic        downstream_ready_i = 1'b0;
    logic        issue_ready_o;
    logic        ex_valid_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        wb_valid_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        redirect_valid_o;
    logic [31:0] redirect_target_o;
    logic        flush_o;
    logic        sb_underflow_o;
`ifdef PIPELINE_HAZARD_PERF_EN
    logic [31:0] stall_count_o;
    logic [31:0] flush_count_o;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_WIDTH(2), .FLUSH_CYCLES(FC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .issue_valid_i     (issue_valid_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs1_used_i  (issue_rs1_used_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_rs2_used_i  (issue_rs2_used_i),
        .issue_rd_i        (issue_rd_i),
        .issue_rd_we_i     (issue_rd_we_i),
        .downstream_ready_i(downstream_ready_i),
        .issue_ready_o     (issue_ready_o),
        .ex_valid_i        (ex_valid_i),
        .branch_taken_i    (branch_taken_i),
        .branch_target_i   (branch_target_i),
        .wb_valid_i        (wb_valid_i),
        .wb_we_i           (wb_we_i),
        .wb_rd_i           (wb_rd_i),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_target_o (redirect_target_o),
        .flush_o           (flush_o),
        .sb_underflow_o    (sb_underflow_o)
`ifdef PIPELINE_HAZARD_PERF_EN
        ,
        .stall_count_o     (stall_count_o),
        .flush_count_o     (flush_count_o)
`endif
    );

    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        fl;
        logic        uf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          cnt[32];
    int          flush_left;
    bit          rv_m;
    logic [31:0] tgt_m;
    bit          uf_m;
    bit          last_rdy;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        flush_left = 0;
        rv_m       = 0;
        tgt_m      = '0;
        uf_m       = 0;
    endtask

    function automatic bit model_hazard();
        return (issue_rs1_used_i && issue_rs1_i != 0 && cnt[issue_rs1_i] != 0)
            || (issue_rs2_used_i && issue_rs2_i != 0 && cnt[issue_rs2_i] != 0)
            || (issue_rd_we_i && issue_rd_i != 0 && cnt[issue_rd_i] == CNT_MAX);
    endfunction

    // Applies one clock edge worth of architectural effects using the inputs of the ending cycle.
    task automatic model_step();
        bit inc, dec;
        inc = issue_valid_i && last_rdy && issue_rd_we_i && issue_rd_i != 0;
        dec = wb_valid_i && wb_we_i && wb_rd_i != 0;
        if (dec && cnt[wb_rd_i] == 0) uf_m = 1;
        if (!(inc && dec && issue_rd_i == wb_rd_i)) begin
            if (dec && cnt[wb_rd_i] > 0) cnt[wb_rd_i]--;
            if (inc) cnt[issue_rd_i]++;
        end
        rv_m = 0;
        if (flush_left == 0 && ex_valid_i && branch_taken_i) begin
            rv_m       = 1;
            tgt_m      = branch_target_i;
            flush_left = FC;
        end else if (flush_left > 0) begin
            flush_left--;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue_ready", 32'(issue_ready_o), 32'(e.rdy));
                chk("redirect_valid", 32'(redirect_valid_o), 32'(e.rv));
                chk("redirect_target", redirect_target_o, e.tgt);
                chk("flush", 32'(flush_o), 32'(e.fl));
                chk("sb_underflow", 32'(sb_underflow_o), 32'(e.uf));
            end
        end
    end

    initial begin : driver
        exp_t e;
        int   rst_hold;
        bit   rst_pending;
        bit   bad_wb;
        int   r;
        model_clear();
        last_rdy    = 0;
        rst_hold    = 2;
        rst_pending = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            if (rst_n) model_step();
            #1;
            if (cyc == 1000 || cyc == 2000) rst_pending = 1;
            if (rst_pending && flush_left > 0) begin
                rst_hold    = 2;
                rst_pending = 0;
            end
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else begin
                rst_n = 1'b1;
            end

            bad_wb = (cyc >= 1500 && cyc < 2000) || cyc >= 2600;
            issue_valid_i      = ($urandom_range(0, 3) != 0);
            issue_rs1_i        = 5'($urandom_range(0, 7));
            issue_rs1_used_i   = ($urandom_range(0, 9) < 7);
            issue_rs2_i        = 5'($urandom_range(0, 7));
            issue_rs2_used_i   = ($urandom_range(0, 9) < 6);
            issue_rd_i         = 5'($urandom_range(0, 7));
            issue_rd_we_i      = ($urandom_range(0, 9) < 8);
            downstream_ready_i = ($urandom_range(0, 9) < 9);
            ex_valid_i         = $urandom_range(0, 1);
            branch_taken_i     = ($urandom_range(0, 9) == 0);
            branch_target_i    = $urandom;
            r                  = $urandom_range(1, 7);
            if (bad_wb) begin
                wb_valid_i = ($urandom_range(0, 3) == 0);
                wb_we_i    = ($urandom_range(0, 5) != 0);
                wb_rd_i    = 5'($urandom_range(0, 7));
            end else begin
                wb_valid_i = (cnt[r] > 0) && ($urandom_range(0, 9) < 3);
                wb_we_i    = 1'b1;
                wb_rd_i    = 5'(r);
            end

            if (!rst_n) model_clear();
            e.rdy = rst_n && flush_left == 0 && downstream_ready_i && !model_hazard()
                    && !(ex_valid_i && branch_taken_i);
            e.rv  = rv_m;
            e.tgt = tgt_m;
            e.fl  = (flush_left > 0);
            e.uf  = uf_m;
            last_rdy = e.rdy;
            exp_q.push_back(e);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
